// File: rtl/shift_pkg.sv
// Shared types for the shift arbiter: request operands, shift direction and
// output-stage state.
package shift_pkg;

  typedef enum logic {SHIFT_LEFT = 1'b0, SHIFT_RIGHT = 1'b1} shift_dir_t;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] amount;
    shift_dir_t dir;
  } shift_req_t;

  localparam int NUM_REQ = 2;

  typedef enum logic {OUT_EMPTY = 1'b0, OUT_FULL = 1'b1} out_state_t;

endpackage

// File: rtl/barrel_shifter.sv
// Combinational 8-bit logical barrel shifter with zero fill.
module barrel_shifter
  import shift_pkg::*;
(
  input  shift_req_t  req_i,
  output logic [7:0]  data_o
);

  always_comb begin
    if (req_i.dir == SHIFT_RIGHT) data_o = req_i.data >> req_i.amount;
    else                          data_o = req_i.data << req_i.amount;
  end

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester arbiter in front of a shared barrel shifter, with a one-deep
// registered output stage, requester tag and per-requester grant counters.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int PRIO_FIXED = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s0_valid,
  output logic       s0_ready,
  input  logic [7:0] s0_data,
  input  logic [2:0] s0_amount,
  input  logic       s0_dir,
  input  logic       s1_valid,
  output logic       s1_ready,
  input  logic [7:0] s1_data,
  input  logic [2:0] s1_amount,
  input  logic       s1_dir,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_id,
  output logic [7:0] grant_cnt0,
  output logic [7:0] grant_cnt1
);

  out_state_t state_q, state_d;
  logic [7:0] m_data_q, m_data_d;
  logic       m_id_q, m_id_d;
  logic       last_grant_q, last_grant_d;
  logic [7:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  logic       can_accept, pref, fire0, fire1, sel;
  shift_req_t req [NUM_REQ];
  logic [7:0] shift_out;

  assign req[0] = '{data: s0_data, amount: s0_amount, dir: shift_dir_t'(s0_dir)};
  assign req[1] = '{data: s1_data, amount: s1_amount, dir: shift_dir_t'(s1_dir)};

  // Each ready looks only at the other requester's valid, never its own, so a
  // requester can sample ready before deciding to assert valid.
  assign can_accept = (state_q == OUT_EMPTY) || m_ready;
  assign pref       = (PRIO_FIXED != 0) ? 1'b0 : ~last_grant_q;
  assign s0_ready   = can_accept && (!s1_valid || (pref == 1'b0));
  assign s1_ready   = can_accept && (!s0_valid || (pref == 1'b1));
  assign fire0      = s0_valid && s0_ready;
  assign fire1      = s1_valid && s1_ready;

  // Idle cycles keep the last winner's operands on the shifter.
  assign sel = fire1 || (!fire0 && last_grant_q);

  barrel_shifter u_shifter (
    .req_i  (req[sel]),
    .data_o (shift_out)
  );

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path
    // through this block can infer a latch.
    state_d      = state_q;
    m_data_d     = m_data_q;
    m_id_d       = m_id_q;
    last_grant_d = last_grant_q;
    cnt0_d       = cnt0_q + {7'd0, fire0};
    cnt1_d       = cnt1_q + {7'd0, fire1};
    if (fire0 || fire1) begin
      state_d      = OUT_FULL;
      m_data_d     = shift_out;
      m_id_d       = fire1;
      last_grant_d = fire1;
    end else if (m_ready) begin
      state_d = OUT_EMPTY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= OUT_EMPTY;
      m_data_q     <= 8'h00;
      m_id_q       <= 1'b0;
      last_grant_q <= 1'b1;
      cnt0_q       <= 8'h00;
      cnt1_q       <= 8'h00;
    end else begin
      state_q      <= state_d;
      m_data_q     <= m_data_d;
      m_id_q       <= m_id_d;
      last_grant_q <= last_grant_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign m_valid    = (state_q == OUT_FULL);
  assign m_data     = m_data_q;
  assign m_id       = m_id_q;
  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: one round-robin and one fixed-priority
// instance share the same stimulus.
module tb_shift_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s0_valid, s1_valid, s0_dir, s1_dir, m_ready;
  logic [7:0] s0_data, s1_data;
  logic [2:0] s0_amount, s1_amount;

  logic       s0_ready, s1_ready, m_valid, m_id;
  logic [7:0] m_data, grant_cnt0, grant_cnt1;
  logic       fx_s0_ready, fx_s1_ready, fx_m_valid, fx_m_id;
  logic [7:0] fx_m_data, fx_grant_cnt0, fx_grant_cnt1;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  shift_arbiter #(.PRIO_FIXED(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_data(s0_data),
    .s0_amount(s0_amount), .s0_dir(s0_dir),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_data(s1_data),
    .s1_amount(s1_amount), .s1_dir(s1_dir),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_id(m_id),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  shift_arbiter #(.PRIO_FIXED(1)) dut_fx (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_ready(fx_s0_ready), .s0_data(s0_data),
    .s0_amount(s0_amount), .s0_dir(s0_dir),
    .s1_valid(s1_valid), .s1_ready(fx_s1_ready), .s1_data(s1_data),
    .s1_amount(s1_amount), .s1_dir(s1_dir),
    .m_valid(fx_m_valid), .m_ready(m_ready), .m_data(fx_m_data), .m_id(fx_m_id),
    .grant_cnt0(fx_grant_cnt0), .grant_cnt1(fx_grant_cnt1)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses reset between clock edges; called from posedge+1.
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  logic [7:0] rr_data [4] = '{8'h66, 8'h3C, 8'h66, 8'h3C};
  logic       rr_id   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] shr_exp [8] = '{8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01};

  initial begin
    rst_n = 1'b0;
    s0_valid = 1'b0; s0_data = 8'h00; s0_amount = 3'd0; s0_dir = 1'b0;
    s1_valid = 1'b0; s1_data = 8'h00; s1_amount = 3'd0; s1_dir = 1'b0;
    m_ready = 1'b1;

    // Reset state
    #12;
    check("rst_m_valid", {7'd0, m_valid}, 8'h00);
    check("rst_m_data", m_data, 8'h00);
    check("rst_m_id", {7'd0, m_id}, 8'h00);
    check("rst_cnt0", grant_cnt0, 8'h00);
    check("rst_cnt1", grant_cnt1, 8'h00);
    @(negedge clk) rst_n = 1'b1;

    // Single request from s0: 0xCC << 1
    s0_valid = 1'b1; s0_data = 8'hCC; s0_amount = 3'd1; s0_dir = 1'b0;
    #1 check("single_s0_ready", {7'd0, s0_ready}, 8'h01);
    tick();
    check("single_m_valid", {7'd0, m_valid}, 8'h01);
    check("single_m_data", m_data, 8'h98);
    check("single_m_id", {7'd0, m_id}, 8'h00);
    check("single_cnt0", grant_cnt0, 8'h01);
    s0_valid = 1'b0;
    tick();
    check("drain_m_valid", {7'd0, m_valid}, 8'h00);
    pulse_reset();

    // Round-robin with both requesters valid
    s0_valid = 1'b1; s0_data = 8'hCC; s0_amount = 3'd1; s0_dir = 1'b1;
    s1_valid = 1'b1; s1_data = 8'h0F; s1_amount = 3'd2; s1_dir = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_s0_ready", {7'd0, s0_ready}, {7'd0, ~rr_id[i]});
      check("rr_s1_ready", {7'd0, s1_ready}, {7'd0, rr_id[i]});
      tick();
      check("rr_m_data", m_data, rr_data[i]);
      check("rr_m_id", {7'd0, m_id}, {7'd0, rr_id[i]});
    end
    check("rr_cnt0", grant_cnt0, 8'h02);
    check("rr_cnt1", grant_cnt1, 8'h02);

    // Backpressure while FULL
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_s0_ready", {7'd0, s0_ready}, 8'h00);
      check("bp_s1_ready", {7'd0, s1_ready}, 8'h00);
      tick();
      check("bp_m_valid", {7'd0, m_valid}, 8'h01);
      check("bp_m_data", m_data, 8'h3C);
      check("bp_m_id", {7'd0, m_id}, 8'h01);
      check("bp_cnt0", grant_cnt0, 8'h02);
      check("bp_cnt1", grant_cnt1, 8'h02);
    end
    m_ready = 1'b1;
    #1 check("bp_release_s0_ready", {7'd0, s0_ready}, 8'h01);
    tick();
    check("bp_release_m_valid", {7'd0, m_valid}, 8'h01);
    check("bp_release_m_data", m_data, 8'h66);
    check("bp_release_m_id", {7'd0, m_id}, 8'h00);
    check("bp_release_cnt0", grant_cnt0, 8'h03);

    // Asynchronous reset while FULL, requests still pending
    #2 rst_n = 1'b0;
    #1;
    check("arst_m_valid", {7'd0, m_valid}, 8'h00);
    check("arst_cnt0", grant_cnt0, 8'h00);
    check("arst_cnt1", grant_cnt1, 8'h00);
    check("arst_fx_m_valid", {7'd0, fx_m_valid}, 8'h00);
    rst_n = 1'b1;
    #1;
    check("arst_s0_ready", {7'd0, s0_ready}, 8'h01);
    check("arst_s1_ready", {7'd0, s1_ready}, 8'h00);

    // Fixed priority instance: requester 0 always wins
    for (int i = 0; i < 3; i++) begin
      check("fx_s1_ready", {7'd0, fx_s1_ready}, 8'h00);
      tick();
      if (i == 0) begin
        check("arst_first_m_id", {7'd0, m_id}, 8'h00);
        check("arst_first_m_data", m_data, 8'h66);
      end
      check("fx_m_valid", {7'd0, fx_m_valid}, 8'h01);
      check("fx_m_id", {7'd0, fx_m_id}, 8'h00);
      check("fx_m_data", fx_m_data, 8'h66);
      #1;
    end
    check("fx_cnt0", fx_grant_cnt0, 8'h03);
    check("fx_cnt1", fx_grant_cnt1, 8'h00);

    // Counter wrap on requester 1
    s0_valid = 1'b0;
    s1_data = 8'hFF; s1_amount = 3'd0; s1_dir = 1'b0;
    pulse_reset();
    for (int i = 0; i < 255; i++) tick();
    check("wrap_cnt1_255", grant_cnt1, 8'hFF);
    check("wrap_cnt0", grant_cnt0, 8'h00);
    tick();
    check("wrap_cnt1_0", grant_cnt1, 8'h00);

    // Shift amounts 0..7 right on 0xFF, then amount 0 left
    s1_dir = 1'b1;
    for (int k = 0; k < 8; k++) begin
      s1_amount = 3'(k);
      tick();
      check("shr_m_data", m_data, shr_exp[k]);
      check("shr_m_id", {7'd0, m_id}, 8'h01);
    end
    s1_amount = 3'd0; s1_dir = 1'b0;
    tick();
    check("shl0_m_data", m_data, 8'hFF);
    s1_valid = 1'b0;
    tick();
    check("idle_m_valid", {7'd0, m_valid}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
